// File: rtl/ast_video_source_arbiter_if.sv
// Avalon-ST video link: data plus valid/ready handshake with packet framing.
// Latency: none, this is a wire bundle.
// Backpressure: the sink drives ready (readyLatency 0); a beat moves when valid & ready.
//
// Signals:
//   data           DATA_WIDTH  symbol
//   valid          1           beat present
//   startofpacket  1           first beat of a packet (data[3:0] carries the packet type)
//   endofpacket    1           last beat of a packet
//   ready          1           sink can take the beat this cycle
interface ast_video_source_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  ready;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/ast_video_source_arbiter.sv
// Frame-granular arbiter: shares one Avalon-ST video sink between two converter outputs.
// Latency: 1 cycle from accepted input beat to dout (single output register).
// Backpressure: granted input sees dout_ready | ~dout_valid; others drained (or stalled when DROP_UNSELECTED=0).
//
// Ports:
//   clock, reset                 single clock, asynchronous active-high reset
//   mode[1:0]                    00/11 fixed ch0, 01 fixed ch1, 10 round-robin per frame
//   din0, din1 (slave)           per-camera Avalon-ST inputs
//   dout (master)                shared Avalon-ST output, registered
//   dout_channel                 channel id of the beat currently on dout
//   drop_count0/1                saturating count of discarded frames (control-packet SOPs)
module ast_video_source_arbiter #(
    parameter int DATA_WIDTH      = 8,
    parameter int DROP_UNSELECTED = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    ast_video_source_arbiter_if.slave  din0,
    ast_video_source_arbiter_if.slave  din1,
    ast_video_source_arbiter_if.master dout,
    output logic                       dout_channel,
    output logic [CNT_WIDTH-1:0]       drop_count0,
    output logic [CNT_WIDTH-1:0]       drop_count1
);

    typedef enum logic [2:0] {
        S_IDLE,      // waiting for a control packet from the candidate channel
        S_CTRL,      // forwarding the control packet
        S_WAIT_VID,  // between control packet and video packet
        S_PASS,      // forwarding a non-video, non-control packet
        S_VIDEO      // forwarding the video packet
    } state_t;

    localparam logic DROP_RDY = (DROP_UNSELECTED != 0);

    state_t                state, state_nxt;
    logic                  grant, grant_nxt;
    logic                  rr_last, rr_last_nxt;

    logic [1:0]            in_vld;
    logic [1:0]            ctrl_sop;
    logic [1:0]            in_rdy;
    logic [1:0]            in_acc;
    logic [1:0]            own;
    logic [1:0]            drop_inc;
    logic                  out_free;
    logic                  pref;
    logic                  cand;
    logic                  win_vld;
    logic                  sel;
    logic                  sel_on;
    logic                  sel_acc;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  sel_sop;
    logic                  sel_eop;

    assign in_vld      = {din1.valid, din0.valid};
    assign ctrl_sop[0] = din0.valid & din0.startofpacket & (din0.data[3:0] == 4'hF);
    assign ctrl_sop[1] = din1.valid & din1.startofpacket & (din1.data[3:0] == 4'hF);

    // Output register can take a beat when it is empty or being emptied this cycle.
    assign out_free = dout.ready | ~dout.valid;

    // Candidate for the next grant. In round-robin the channel not served last is
    // preferred, but the other one may take the slot if only it has a frame ready.
    always_comb begin
        pref    = ~rr_last;
        cand    = 1'b0;
        case (mode)
            2'b01:   cand = 1'b1;
            2'b10:   cand = (ctrl_sop[pref] | ~ctrl_sop[~pref]) ? pref : ~pref;
            default: cand = 1'b0;
        endcase
        win_vld = ctrl_sop[cand];
    end

    // In IDLE the selected channel only owns the output once it shows a control SOP;
    // until then it is treated like any other non-granted channel and drained.
    assign sel    = (state == S_IDLE) ? cand : grant;
    assign sel_on = (state != S_IDLE) | win_vld;
    assign own    = {sel_on & sel, sel_on & ~sel};

    // Readies are forced low during reset so nothing is accepted or counted.
    assign in_rdy[0] = ~reset & (own[0] ? out_free : DROP_RDY);
    assign in_rdy[1] = ~reset & (own[1] ? out_free : DROP_RDY);
    assign din0.ready = in_rdy[0];
    assign din1.ready = in_rdy[1];

    assign in_acc   = in_vld & in_rdy;
    assign sel_acc  = |(in_acc & own);
    assign drop_inc = in_acc & ctrl_sop & ~own;

    assign sel_dat = sel ? din1.data          : din0.data;
    assign sel_sop = sel ? din1.startofpacket : din0.startofpacket;
    assign sel_eop = sel ? din1.endofpacket   : din0.endofpacket;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            grant   <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_last <= rr_last_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_last_nxt = rr_last;
        case (state)
            S_IDLE: begin
                if (sel_acc) begin
                    grant_nxt = cand;
                    state_nxt = sel_eop ? S_WAIT_VID : S_CTRL;
                end
            end
            S_CTRL: begin
                if (sel_acc && sel_eop) begin
                    state_nxt = S_WAIT_VID;
                end
            end
            S_WAIT_VID: begin
                if (sel_acc && sel_sop) begin
                    case (sel_dat[3:0])
                        4'h0: begin
                            if (sel_eop) begin
                                state_nxt   = S_IDLE;
                                rr_last_nxt = grant;
                            end else begin
                                state_nxt = S_VIDEO;
                            end
                        end
                        // A repeated control packet replaces the earlier one downstream.
                        4'hF:    state_nxt = sel_eop ? S_WAIT_VID : S_CTRL;
                        default: state_nxt = sel_eop ? S_WAIT_VID : S_PASS;
                    endcase
                end
            end
            S_PASS: begin
                if (sel_acc && sel_eop) begin
                    state_nxt = S_WAIT_VID;
                end
            end
            S_VIDEO: begin
                if (sel_acc && sel_eop) begin
                    state_nxt   = S_IDLE;
                    rr_last_nxt = grant;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register: loads only when free, so contents hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout.data          <= '0;
            dout.valid         <= 1'b0;
            dout.startofpacket <= 1'b0;
            dout.endofpacket   <= 1'b0;
            dout_channel       <= 1'b0;
        end else if (sel_acc) begin
            dout.data          <= sel_dat;
            dout.valid         <= 1'b1;
            dout.startofpacket <= sel_sop;
            dout.endofpacket   <= sel_eop;
            dout_channel       <= sel;
        end else if (dout.ready) begin
            dout.valid         <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_count0 <= '0;
            drop_count1 <= '0;
        end else begin
            if (drop_inc[0] && (drop_count0 != '1)) begin
                drop_count0 <= drop_count0 + CNT_WIDTH'(1);
            end
            if (drop_inc[1] && (drop_count1 != '1)) begin
                drop_count1 <= drop_count1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ast_video_source_arbiter.sv
// Bench for ast_video_source_arbiter: random frames on both inputs, expected dout
// beats queued at issue time and popped by an independent monitor.
module tb_ast_video_source_arbiter;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode  = 2'b00;
    logic          dout_channel;
    logic [CW-1:0] drop_count0;
    logic [CW-1:0] drop_count1;

    ast_video_source_arbiter_if #(.DATA_WIDTH(DW)) din0();
    ast_video_source_arbiter_if #(.DATA_WIDTH(DW)) din1();
    ast_video_source_arbiter_if #(.DATA_WIDTH(DW)) dout();

    ast_video_source_arbiter #(
        .DATA_WIDTH(DW),
        .DROP_UNSELECTED(1),
        .CNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mode(mode),
        .din0(din0),
        .din1(din1),
        .dout(dout),
        .dout_channel(dout_channel),
        .drop_count0(drop_count0),
        .drop_count1(drop_count1)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          ch;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    acc_cnt[2];
    int    switch_at = -1;
    bit    rnd_rdy   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Downstream ready: solid 1 or a 50% random pattern.
    initial begin
        dout.ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            dout.ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on every handshake, stability while stalled.
    beat_t mon_cur;
    beat_t prev_beat;
    beat_t exp_beat;
    bit    prev_hold     = 1'b0;
    int    first_out_cyc = -1;
    bit    watch_rdy1    = 1'b0;
    int    rdy1_low      = 0;

    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            mon_cur = '{dout.data, dout.startofpacket, dout.endofpacket, dout_channel};
            if (prev_hold) begin
                check("dout_stable_while_stalled", 64'({dout.valid, mon_cur}), 64'({1'b1, prev_beat}));
            end
            if (dout.valid && dout.ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", mon_cur, cyc);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("dout_beat", 64'(mon_cur), 64'(exp_beat));
                end
            end
            if (watch_rdy1 && !din1.ready) rdy1_low++;
            prev_hold = dout.valid & ~dout.ready;
            prev_beat = mon_cur;
        end
    end

    task automatic set_valid(input bit ch, input logic v);
        if (ch) din1.valid = v;
        else    din0.valid = v;
    endtask

    task automatic drive_beat(input bit ch, input logic [DW-1:0] d, input logic s, input logic e, input bit gap);
        logic r;
        if (gap) begin
            while ($urandom_range(0, 3) == 0) begin
                set_valid(ch, 1'b0);
                @(posedge clock);
                #1;
            end
        end
        if (ch) begin
            din1.data = d; din1.startofpacket = s; din1.endofpacket = e; din1.valid = 1'b1;
        end else begin
            din0.data = d; din0.startofpacket = s; din0.endofpacket = e; din0.valid = 1'b1;
        end
        r = 1'b0;
        while (!r) begin
            @(negedge clock);
            r = ch ? din1.ready : din0.ready;
            @(posedge clock);
            #1;
        end
        acc_cnt[ch]++;
        if (!ch && acc_cnt[0] == switch_at) mode = 2'b01;
    endtask

    // One frame: control packet, optional extra packet (ancillary 0xD or repeated
    // control 0xF), then video. n_ctrl returns how many control SOPs it carried.
    task automatic send_frame(input bit ch, input int nctrl, input int nanc, input bit anc_f,
                              input int nvid, input bit push, input bit gaps, output int n_ctrl);
        beat_t         b[$];
        int            lens[3];
        logic [3:0]    typ[3];
        logic [DW-1:0] d;
        lens = '{nctrl, nanc, nvid};
        typ  = '{4'hF, (anc_f ? 4'hF : 4'hD), 4'h0};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < lens[p]; i++) begin
                d = 8'($urandom);
                if (i == 0) d[3:0] = typ[p];
                b.push_back('{d, (i == 0), (i == lens[p] - 1), ch});
            end
        end
        if (push) begin
            foreach (b[i]) exp_q.push_back(b[i]);
        end
        foreach (b[i]) drive_beat(ch, b[i].data, b[i].sop, b[i].eop, gaps && (i > 0));
        set_valid(ch, 1'b0);
        n_ctrl = 1 + ((nanc > 0 && anc_f) ? 1 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("outputs_in_reset",
                  64'({dout.valid, dout.data, dout.startofpacket, dout.endofpacket, dout_channel,
                       din0.ready, din1.ready, drop_count0, drop_count1}), 64'(0));
        end
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        do @(negedge clock); while (exp_q.size() != 0 || dout.valid);
        @(posedge clock);
        #1;
    endtask

    // Global bound on every wait for the DUT.
    initial begin
        repeat (60000) @(posedge clock);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d, expected test completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    int n0, n1, exp_d0, exp_d1, t0, base;

    initial begin
        din0.valid = 1'b0; din0.data = '0; din0.startofpacket = 1'b0; din0.endofpacket = 1'b0;
        din1.valid = 1'b0; din1.data = '0; din1.startofpacket = 1'b0; din1.endofpacket = 1'b0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;

        // Fixed ch0 with ch1 running concurrently: ch1 drained and counted.
        do_reset();
        mode = 2'b00;
        rnd_rdy = 1'b0;
        exp_d1 = 0;
        @(posedge clock);
        #1;
        t0 = cyc;
        first_out_cyc = -1;
        watch_rdy1 = 1'b1;
        rdy1_low = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(1'b0, 9, 0, 1'b0, 48, 1'b1, 1'b0, n0);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    send_frame(1'b1, $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                               $urandom_range(2, 20), 1'b0, 1'b1, n1);
                    exp_d1 += n1;
                end
            end
        join
        wait_drain();
        watch_rdy1 = 1'b0;
        check("first_beat_latency", 64'(first_out_cyc - t0), 64'(1));
        check("din1_ready_low_cycles", 64'(rdy1_low), 64'(0));
        check("fixed_drop_count1", 64'(drop_count1), 64'(exp_d1));
        check("fixed_drop_count0", 64'(drop_count0), 64'(0));

        // Round-robin, simultaneous frames each round, random downstream stalls.
        do_reset();
        mode = 2'b10;
        rnd_rdy = 1'b1;
        exp_d0 = 0;
        exp_d1 = 0;
        for (int r = 0; r < 4; r++) begin
            fork
                send_frame(1'b0, $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                           $urandom_range(2, 24), (r % 2 == 0), 1'b1, n0);
                send_frame(1'b1, $urandom_range(1, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                           $urandom_range(2, 24), (r % 2 == 1), 1'b1, n1);
            join
            if (r % 2 == 0) exp_d1 += n1;
            else            exp_d0 += n0;
            wait_drain();
        end
        check("rr_drop_count0", 64'(drop_count0), 64'(exp_d0));
        check("rr_drop_count1", 64'(drop_count1), 64'(exp_d1));

        // Mode switch 00->01 in the middle of a ch0 video packet.
        do_reset();
        mode = 2'b00;
        rnd_rdy = 1'b1;
        switch_at = acc_cnt[0] + 9 + 10;
        fork
            send_frame(1'b0, 9, 0, 1'b0, 32, 1'b1, 1'b1, n0);
            send_frame(1'b1, 2, 0, 1'b0, 6, 1'b0, 1'b1, n1);
        join
        wait_drain();
        switch_at = -1;
        exp_d1 = n1;
        check("mode_after_switch", 64'(mode), 64'(2'b01));
        fork
            send_frame(1'b0, 3, 0, 1'b0, 8, 1'b0, 1'b1, n0);
            send_frame(1'b1, 3, 0, 1'b0, 8, 1'b1, 1'b1, n1);
        join
        wait_drain();
        check("switch_drop_count0", 64'(drop_count0), 64'(n0));
        check("switch_drop_count1", 64'(drop_count1), 64'(exp_d1));

        // Reset in the middle of a video packet; remainder drained, restart on ctrl SOP.
        do_reset();
        mode = 2'b00;
        rnd_rdy = 1'b0;
        base = acc_cnt[0];
        fork
            send_frame(1'b0, 4, 0, 1'b0, 40, 1'b1, 1'b0, n0);
            begin
                wait (acc_cnt[0] >= base + 4 + 15);
                do_reset();
            end
        join
        send_frame(1'b0, 3, 1, 1'b0, 10, 1'b1, 1'b0, n0);
        wait_drain();
        check("post_reset_drop_count0", 64'(drop_count0), 64'(0));
        check("post_reset_drop_count1", 64'(drop_count1), 64'(0));

        // Counter saturation: 2^CW + 3 frames discarded on ch0.
        do_reset();
        mode = 2'b01;
        for (int f = 0; f < (1 << CW) + 3; f++) begin
            send_frame(1'b0, 2, 0, 1'b0, 3, 1'b0, 1'b0, n0);
            if (f == 14) check("drop_count0_at_15", 64'(drop_count0), 64'(15));
        end
        repeat (2) @(posedge clock);
        #1;
        check("drop_count0_saturated", 64'(drop_count0), 64'(4'hF));
        check("sat_drop_count1", 64'(drop_count1), 64'(0));
        check("sat_no_output", 64'({dout.valid, exp_q.size()}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
